// File: rtl/hazard_controller_pkg.sv
// Shared encodings for the hazard controller: FSM states and execute-stage forward selects.
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        BR_STALL = 2'b10
    } haz_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/forward_unit.sv
// Execute-stage forward select for one ALU operand; the memory stage wins over writeback.
module forward_unit
    import hazard_controller_pkg::*;
#(
    parameter int unsigned REG_ADDR = 5
) (
    input  logic [REG_ADDR-1:0] src,
    input  logic [REG_ADDR-1:0] dst_m,
    input  logic                we_m,
    input  logic [REG_ADDR-1:0] dst_w,
    input  logic                we_w,
    output logic [1:0]          fwd
);

    logic src_live;

    // Register 0 is hard-wired to zero and never needs a bypass.
    assign src_live = (src != '0);

    always_comb begin
        fwd = FWD_RF;
        if (src_live && we_m && (src == dst_m)) begin
            fwd = FWD_MEM;
        end else if (src_live && we_w && (src == dst_w)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Five-stage MIPS hazard unit: forwarding, load-use/branch stalls, state FSM and stall watchdog.
// Performance counters exist only when HAZARD_PERF_CNT_EN is defined; otherwise they read zero.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned REG_ADDR  = 5,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [REG_ADDR-1:0]  RsD,
    input  logic [REG_ADDR-1:0]  RtD,
    input  logic [REG_ADDR-1:0]  RsE,
    input  logic [REG_ADDR-1:0]  RtE,
    input  logic [REG_ADDR-1:0]  WriteRegE,
    input  logic [REG_ADDR-1:0]  WriteRegM,
    input  logic [REG_ADDR-1:0]  WriteRegW,
    input  logic                 RegWriteE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 MemtoRegE,
    input  logic                 MemtoRegM,
    input  logic                 BranchD,
    input  logic [1:0]           PCSrcD,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushE,
    output logic                 FlushD,
    output logic                 ForwardAD,
    output logic                 ForwardBD,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic [1:0]           HazState,
    output logic                 HazErr,
    output logic [CNT_WIDTH-1:0] StallCnt,
    output logic [CNT_WIDTH-1:0] FlushCnt
);

    function automatic logic reg_match(input logic [REG_ADDR-1:0] a, input logic [REG_ADDR-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    logic       lwstall;
    logic       brstall;
    logic       stall;
    haz_state_t state;
    logic [1:0] consec;
    logic       err;

    forward_unit #(.REG_ADDR(REG_ADDR)) u_fwd_a (
        .src   (RsE),
        .dst_m (WriteRegM),
        .we_m  (RegWriteM),
        .dst_w (WriteRegW),
        .we_w  (RegWriteW),
        .fwd   (ForwardAE)
    );

    forward_unit #(.REG_ADDR(REG_ADDR)) u_fwd_b (
        .src   (RtE),
        .dst_m (WriteRegM),
        .we_m  (RegWriteM),
        .dst_w (WriteRegW),
        .we_w  (RegWriteW),
        .fwd   (ForwardBE)
    );

    assign ForwardAD = RegWriteM && reg_match(RsD, WriteRegM);
    assign ForwardBD = RegWriteM && reg_match(RtD, WriteRegM);

    assign lwstall = MemtoRegE && (reg_match(RsD, WriteRegE) || reg_match(RtD, WriteRegE));
    assign brstall = BranchD &&
        ((RegWriteE && (reg_match(RsD, WriteRegE) || reg_match(RtD, WriteRegE))) ||
         (MemtoRegM && (reg_match(RsD, WriteRegM) || reg_match(RtD, WriteRegM))));
    assign stall   = lwstall || brstall;

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;
    // A stalled decode keeps its instruction, so the redirect flush must wait.
    assign FlushD = (PCSrcD != 2'b00) && !stall;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= RUN;
            consec <= 2'd0;
            err    <= 1'b0;
        end else begin
            if (lwstall) begin
                state <= LU_STALL;
            end else if (brstall) begin
                state <= BR_STALL;
            end else begin
                state <= RUN;
            end
            if (stall) begin
                if (consec != 2'd3) begin
                    consec <= consec + 2'd1;
                end
                // Third back-to-back stall is beyond anything legal traffic produces.
                if (consec >= 2'd2) begin
                    err <= 1'b1;
                end
            end else begin
                consec <= 2'd0;
            end
        end
    end

    assign HazState = state;
    assign HazErr   = err;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallD && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (FlushD && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign StallCnt = stall_cnt;
    assign FlushCnt = flush_cnt;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule
